// File: rtl/booth_wallace.sv
// booth_wallace -- 16x16 unsigned multiplier with a registered 32-bit product.
//
// Datapath: radix-4 Booth recoding of b produces nine partial products
// (0, +/-a, +/-2a). A carry-save Wallace tree of 3:2 compressors reduces
// them, plus one row of negation-correction bits, to two rows. A final
// carry-propagate adder sums those rows. Only the product register holds state.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset; clears p
//   a      in  16   multiplicand, unsigned
//   b      in  16   multiplier, unsigned
//   p      out 32   registered product a*b, one cycle after a/b are sampled

module booth_wallace (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    // b zero-extended to 18 bits, with the implicit 0 appended below bit 0.
    logic [18:0] bExt;
    logic [31:0] ppRow [9];
    logic [31:0] corrRow;

    logic [31:0] s10, c10, s11, c11, s12, c12;
    logic [31:0] s20, c20, s21, c21;
    logic [31:0] s30, c30;
    logic [31:0] s40, c40;
    logic [31:0] s50, c50;

    logic [31:0] p_d;
    logic [31:0] p_q;

    assign bExt = {2'b00, b, 1'b0};

    // Bitwise 3:2 compressor over whole rows. The carry row is shifted up one
    // place, and any carry out of bit 31 is dropped because the result is
    // taken modulo 2^32.
    function automatic logic [63:0] csa(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] z);
        logic [31:0] s;
        logic [31:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // Booth recoding. Each digit selects a or 2a, and negative digits take the
    // one's complement. The +1 that completes the two's complement is placed
    // at bit 2i of a separate correction row. The complement is formed across
    // all 32 bits before shifting, so the row is fully sign-extended.
    always_comb begin
        logic [2:0]  trip;
        logic [31:0] mag;
        logic        neg;
        corrRow = '0;
        for (int i = 0; i < 9; i++) begin
            trip = bExt[2*i+2 -: 3];
            mag  = '0;
            neg  = 1'b0;
            unique case (trip)
                3'b001, 3'b010: mag = {16'b0, a};
                3'b011:         mag = {15'b0, a, 1'b0};
                3'b100: begin
                    mag = {15'b0, a, 1'b0};
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = {16'b0, a};
                    neg = 1'b1;
                end
                default: begin
                    mag = '0;
                    neg = 1'b0;
                end
            endcase
            ppRow[i]     = (neg ? ~mag : mag) << (2 * i);
            corrRow[2*i] = neg;
        end
    end

    // Wallace reduction: 10 rows -> 7 -> 5 -> 4 -> 3 -> 2.
    assign {c10, s10} = csa(ppRow[0], ppRow[1], ppRow[2]);
    assign {c11, s11} = csa(ppRow[3], ppRow[4], ppRow[5]);
    assign {c12, s12} = csa(ppRow[6], ppRow[7], ppRow[8]);

    assign {c20, s20} = csa(s10, c10, s11);
    assign {c21, s21} = csa(c11, s12, c12);

    assign {c30, s30} = csa(s20, c20, s21);

    assign {c40, s40} = csa(s30, c30, c21);

    assign {c50, s50} = csa(s40, c40, corrRow);

    // The final carry-propagate adder merges the last sum and carry rows.
    assign p_d = s50 + c50;

    // Product register. Reset wins over the computed product, so an in-flight
    // result is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_booth_wallace.sv
// tb_booth_wallace -- scoreboard bench for booth_wallace.
//
// The driver changes inputs on the falling edge and pushes the expected
// product into a queue. The monitor wakes just after each rising edge and pops
// one entry if any is pending, then compares it with p.

module tb_booth_wallace;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;

    typedef struct {
        logic [31:0] expected;
        logic [15:0] opA;
        logic [15:0] opB;
        logic        rstN;
        int          tag;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int passCount  = 0;
    int tagCount   = 0;

    logic [15:0] crossVals [8];

    booth_wallace dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .p     (p)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operand pair at the falling edge and record what p must be
    // after the next rising edge.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vrst, input logic [31:0] want);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        rst_n = vrst;
        e.expected = want;
        e.opA      = va;
        e.opB      = vb;
        e.rstN     = vrst;
        e.tag      = tagCount;
        tagCount++;
        expQ.push_back(e);
    endtask

    // Compare p with one scoreboard entry.
    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (p === e.expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL prod#%0d a=%h b=%h rst_n=%b got p=%h expected %h",
                     e.tag, e.opA, e.opB, e.rstN, p, e.expected);
        end
    endtask

    // Reference product for the generated vectors.
    function automatic logic [31:0] refMul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx;
        logic [31:0] yy;
        xx = {16'b0, x};
        yy = {16'b0, y};
        return xx * yy;
    endfunction

    // Monitor: runs just after each rising edge and consumes the entry whose
    // operands were sampled at that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int waitCycles;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n = 1'b0;
        a     = 'x;
        b     = 'x;

        crossVals[0] = 16'h0001; crossVals[1] = 16'h0000;
        crossVals[2] = 16'hFFFF; crossVals[3] = 16'h00FF;
        crossVals[4] = 16'h7800; crossVals[5] = 16'h8C1B;
        crossVals[6] = 16'h92A3; crossVals[7] = 16'h7DA2;

        // Reset held for two edges with all-ones operands, then released.
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);

        // Directed vectors with hand-computed products.
        applyStimulus(16'h0001, 16'h8C1B, 1'b1, 32'h0000_8C1B);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 32'h0000_0000);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 32'h0000_0000);
        applyStimulus(16'h00FF, 16'hFFFF, 1'b1, 32'h00FE_FF01);
        applyStimulus(16'h7800, 16'h7DA2, 1'b1, 32'h3AE3_F000);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        applyStimulus(16'h8000, 16'hFFFF, 1'b1, 32'h7FFF_8000);
        applyStimulus(16'h5555, 16'h0003, 1'b1, 32'h0000_FFFF);
        applyStimulus(16'h0002, 16'h0003, 1'b1, 32'h0000_0006);
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 32'h0000_FFFF);

        // 8x8 cross product, back to back.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(crossVals[i], crossVals[j], 1'b1,
                              refMul(crossVals[i], crossVals[j]));
            end
        end

        // Back-to-back stream with a one-cycle reset pulse in the middle.
        for (int k = 0; k < 64; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k == 30) begin
                applyStimulus(ra, rb, 1'b0, 32'h0000_0000);
            end else begin
                applyStimulus(ra, rb, 1'b1, refMul(ra, rb));
            end
        end

        // Random operands.
        for (int k = 0; k < 10000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus(ra, rb, 1'b1, refMul(ra, rb));
        end

        // Drain the scoreboard with a bounded wait.
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/booth_wallace.md
Name: booth_wallace

Overview:
- 16x16 unsigned integer multiplier producing a full 32-bit product.
- Core is combinational:
  - radix-4 (modified) Booth partial-product generation,
  - Wallace-tree carry-save reduction,
  - final carry-propagate adder.
- The product is captured in an output register.
- Used as a single-cycle-latency arithmetic block in the datapath.

Parameters:
- None. Operand width is fixed at 16 bits and product width at 32 bits.

Ports:
- clk    input   1   rising-edge clock
- rst_n  input   1   synchronous reset, active-low (sampled on rising clk edge)
- a      input   16  multiplicand, unsigned
- b      input   16  multiplier, unsigned
- p      output  32  registered product a*b, unsigned

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). There is no asynchronous reset path.
- Reset:
  - On a rising clk edge with rst_n=0, p <= 32'h0000_0000.
  - Reset has priority over the computed product.
  - Reset asserted mid-stream discards the in-flight product.
  - p stays 0 for every cycle rst_n is held low.
- Normal operation:
  - On every rising clk edge with rst_n=1, p <= a*b.
  - Latency: exactly 1 cycle from a/b sampled at edge N to p valid after edge N.
  - Throughput: 1 product per cycle.
  - No handshake and no valid/ready; a new operand pair is accepted every cycle.
- Arithmetic:
  - Operands are unsigned; the product is exact modulo 2^32 (a full 16x16 product never overflows 32 bits).
  - Example: 16'hFFFF*16'hFFFF = 32'hFFFE_0001.
- Booth encoding:
  - Zero-extend b to 18 bits (two leading zeros) and append an implicit 0 below bit 0.
  - Recode overlapping 3-bit groups {b[2i+1],b[2i],b[2i-1]}, i=0..8, giving 9 digits in {-2,-1,0,+1,+2}.
  - Each partial product is 0, +/-a or +/-2a. Negation is one's-complement plus a correction '1' injected at the LSB of that row.
  - Sign-extension uses the standard constant-1/inverted-sign trick, or full sign extension to 32 bits. Either is acceptable if the result is exact.
- Reduction:
  - Reduce the 9 partial products plus the correction bits with a Wallace tree of full adders (3:2) and half adders down to two rows.
  - Add the two rows with a 32-bit carry-propagate adder.
  - Carries beyond bit 31 are discarded.
- The combinational path from a/b to the D input of the p register must settle within one clock period. Nothing in the datapath is registered other than p.
- No X propagation: p is deterministic after the first reset edge, even if a/b are X before reset.
- Behavioural '*' must not be used in the datapath. The product must come from the Booth/Wallace structure.

Test Plan:
- Reset: drive rst_n=0, a=16'hFFFF, b=16'hFFFF, clock 2 edges -> p=32'h0000_0000. Release rst_n -> p=32'hFFFE_0001 after the next edge.
- Identity and zero: a=16'h0001,b=16'h8C1B -> p=32'h0000_8C1B; a=16'hFFFF,b=16'h0000 -> p=0; a=16'h0000,b=16'h0000 -> p=0.
- Booth-digit coverage:
  - a=16'h00FF,b=16'hFFFF -> p=32'h00FE_FF01.
  - a=16'h7800,b=16'h7DA2 -> p=32'h3AE3_F000.
  - The 8x8 cross product of {0001,0000,FFFF,00FF,7800,8C1B,92A3,7DA2} for a and b matches a reference a*b every cycle.
- Pipeline/latency: change a/b every cycle for 64 consecutive cycles -> each p equals the product of the pair sampled one edge earlier, with no bubbles.
- Reset mid-operation: assert rst_n=0 for one edge during a back-to-back stream -> p=0 for that cycle only. The next edge yields the product of the operands present at that edge.
- Random: 10,000 random unsigned a/b pairs -> p matches a*b (32-bit) in every case, including MSB-set operands such as 16'h8000*16'h8000=32'h4000_0000.
